alu_operand_sequencer: RTL
==========================

# alu_operand_sequencer

Upstream input stage for the 8-bit ALU board design. An operator sets the data switches, then presses one pushbutton three times to enter operand A, operand B and the opcode in turn. A second button clears the entry. Both buttons are debounced. The block holds the latched A/B/op stable for the ALU and signals when a complete operand set is present. Its outputs drive the ALU `A`, `B` and `op` inputs directly. `stage` feeds status LEDs.

## Interface
Parameters:
- `W`, 8: operand width. Must be ≥ 3.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a button level change. The board build overrides it, e.g. 500000 at 50 MHz. Must be ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous active-low reset.
- `sw`  in  W: data switches. Asynchronous, quasi-static. Sampled only on a capture edge.
- `key_n`  in  1: enter button, active-low, asynchronous, bouncy.
- `clr_n`  in  1: clear button, active-low, asynchronous, bouncy.
- `a`  out  W: latched operand A.
- `b`  out  W: latched operand B.
- `op`  out  3: latched opcode.
- `valid`  out  1: high while a complete A/B/op set is held.
- `stage`  out  2: current FSM state encoding.

## Operation
- **Input synchronisation:** each button passes through its own 2-flop synchronizer. Both synchronizer flops reset to 1 (released).
- **Debounce, one instance per button:**
  - Each instance holds a debounced level `deb` (reset 1) and a counter (reset 0).
  - If the synced level equals `deb`, the counter returns to 0.
  - Otherwise the counter increments. On the edge where the counter is at `DEBOUNCE_CYCLES-1` and the level still mismatches, `deb` takes the synced level and the counter returns to 0.
  - Each instance has a `deb_prev` register. The press pulse is `deb_prev & ~deb`, which is high for exactly one cycle per accepted press.
  - A release is debounced the same way but produces no event.
- **FSM states and transitions:**
  - LOAD_A = 0: on key press, `a <= sw`, go to LOAD_B.
  - LOAD_B = 1: on key press, `b <= sw`, go to LOAD_OP.
  - LOAD_OP = 2: on key press, `op <= sw[2:0]`, `valid <= 1`, go to SHOW.
  - SHOW = 3: on key press, `valid <= 0`, go to LOAD_A. `a`, `b` and `op` keep their values until overwritten.
- **Clear:** a clr press in any state forces LOAD_A and sets `a`, `b`, `op` and `valid` to 0.
- **Simultaneous key and clr press pulses in the same cycle:** clr wins and the key press is discarded.
- **Held button:** produces exactly one press event. The next event requires a debounced release followed by a new press.
- **Registers and stable outputs:** all outputs come straight from registers, so the ALU and displays see no combinational glitches. `a`, `b` and `op` change only on capture or clear edges.

## Timing
- **Reset values:** `a` = 0, `b` = 0, `op` = 0, `valid` = 0, `stage` = 0 (LOAD_A). All internal debounce state returns to its released condition.
- Reset takes effect immediately on assertion, regardless of the clock. It is released synchronously by the system (external concern).
- **Capture latency:** suppose `key_n` is first sampled low at edge e0 and stays clean. Then `deb` falls at edge e0+1+`DEBOUNCE_CYCLES`, and the register capture and state change occur at edge e0+`DEBOUNCE_CYCLES`+2. `sw` is sampled at that same edge.
- **Clear latency:** identical to capture latency.
- **Bounce rejection:** any low pulse shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output resets the counter and produces no event.
- **Timing of `valid`:** `valid` rises on the same edge that `op` is captured and falls on the leaving edge.
- **Reset mid-operation:** a reset in any state, including during an active debounce count, returns the block to LOAD_A. No event is generated on release even if a button is still held: `deb` must first fall, which requires a full debounce interval from the released state.

## Test plan
With `DEBOUNCE_CYCLES` = 4:
- **Reset values:** assert `rst_n` = 0 mid-cycle with both buttons high → `a`/`b`/`op`/`valid`/`stage` are 0 immediately, before the next clock edge.
- **Full entry sequence:** press with `sw` = 0x3C, then `sw` = 0xA5, then `sw` = 0x02 (6-cycle holds, 6-cycle gaps) → `a` = 0x3C, `b` = 0xA5, `op` = 2, `valid` = 1, `stage` = 3. The first capture lands exactly 6 edges after `key_n` is first sampled low. A fourth press → `valid` = 0, `stage` = 0, `a` still 0x3C.
- **Bounce rejection:** in LOAD_A, `key_n` low for 3 cycles, high for 1, then low for 3 → no capture, `stage` stays 0. A following low of 5 cycles → exactly one capture.
- **Held button:** hold `key_n` low for 100 cycles → exactly one state advance.
- **Clear mid-entry:** clear in LOAD_OP after A = 0x11 and B = 0x22 → `a` = `b` = `op` = 0, `stage` = 0. A clr pulse and a key pulse aligned to the same cycle → clear takes effect and the key press is ignored.
- **Reset mid-operation:** assert reset in LOAD_B while `key_n` is held low → after release `stage` = 0. No capture occurs until `key_n` has been held low continuously for 4 cycles at the synchronizer output following reset release.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Operand entry stage for the 8-bit ALU board: debounces the enter/clear
// buttons and steps through A, B and opcode capture with registered outputs.
module alu_operand_sequencer #(
  parameter int W               = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic         key_n,
  input  logic         clr_n,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [2:0]   op,
  output logic         valid,
  output logic [1:0]   stage
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    SHOW    = 2'd3
  } state_t;

  // Bit 0 is the enter button, bit 1 the clear button.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_prev;
  logic [1:0]    press;
  logic [CW-1:0] cnt [2];
  state_t        state;

  assign raw = {clr_n, key_n};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb      <= 2'b11;
      deb_prev <= 2'b11;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      deb_prev <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press = deb_prev & ~deb;

  // Clear takes priority over a coincident enter press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      valid <= 1'b0;
    end else if (press[1]) begin
      state <= LOAD_A;
      a     <= '0;
      b     <= '0;
      op    <= '0;
      valid <= 1'b0;
    end else if (press[0]) begin
      case (state)
        LOAD_A: begin
          a     <= sw;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= sw;
          state <= LOAD_OP;
        end
        LOAD_OP: begin
          op    <= sw[2:0];
          valid <= 1'b1;
          state <= SHOW;
        end
        default: begin
          valid <= 1'b0;
          state <= LOAD_A;
        end
      endcase
    end
  end

  assign stage = state;

endmodule
